// File: rtl/video_stream_tx.sv
// Credit-based raster pixel launcher with a fixed-latency capture FIFO and a valid/ready output.
// Optional underrun counter is compiled in when VSTREAM_UNDERRUN_CNT_EN is defined.
module video_stream_tx #(
  parameter int CD    = 12,
  parameter int HMAX  = 640,
  parameter int VMAX  = 480,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sync_clr,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          pix_inc,
  input  logic [CD-1:0] si_rgb,
  output logic [CD:0]   so_data,
  output logic          so_valid,
  input  logic          so_ready,
  output logic [15:0]   underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 2;
  localparam logic [10:0] X_LAST = 11'(HMAX - 1);
  localparam logic [10:0] Y_LAST = 11'(VMAX - 1);

  logic [LAT-1:0] vld_line;
  logic [LAT-1:0] fs_line;
  logic [CD:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    occ;
  logic [SW-1:0]  inflight;
  logic [SW-1:0]  credit_used;
  logic           launch_fs;
  logic           push;
  logic           pop;

  // Every launched pixel still owns a credit until it leaves the FIFO, so a capture never overflows.
  always_comb begin
    // NOTE: combinational accumulators use blocking assignments and get a default first, so no latch is inferred.
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + SW'(vld_line[i]);
    credit_used = SW'(occ) + inflight;
    pix_inc     = (credit_used < SW'(DEPTH));
    launch_fs   = (x == '0) && (y == '0);
  end

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (sync_clr) begin
      x <= '0;
      y <= '0;
    end else if (pix_inc) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_line <= '0;
      fs_line  <= '0;
    end else begin
      vld_line[0] <= pix_inc;
      fs_line[0]  <= launch_fs;
      for (int i = 1; i < LAT; i++) begin
        vld_line[i] <= vld_line[i-1];
        fs_line[i]  <= fs_line[i-1];
      end
    end
  end

  assign push     = vld_line[LAT-1];
  assign so_valid = (occ != '0);
  assign pop      = so_valid && so_ready;
  assign so_data  = so_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array is not reset; occ gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {si_rgb, fs_line[LAT-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef VSTREAM_UNDERRUN_CNT_EN
  logic started;

  // Starvation is only meaningful once the sink has seen the first frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      started      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (pop && so_data[0]) started <= 1'b1;
      if (started && so_ready && !so_valid && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_video_stream_tx.sv
// Randomized bench for video_stream_tx against a transaction-level model of launched-but-unpopped pixels.
// The daisy chain is modelled as a LAT-cycle delay of {x[5:0], y[5:0]}.
module tb_video_stream_tx;
  localparam int CD    = 12;
  localparam int HMAX  = 128;
  localparam int VMAX  = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sync_clr;
  logic [10:0]   x;
  logic [10:0]   y;
  logic          pix_inc;
  logic [CD-1:0] si_rgb;
  logic [CD:0]   so_data;
  logic          so_valid;
  logic          so_ready;
  logic [15:0]   underrun_cnt;

  video_stream_tx #(.CD(CD), .HMAX(HMAX), .VMAX(VMAX), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sync_clr(sync_clr), .x(x), .y(y), .pix_inc(pix_inc),
    .si_rgb(si_rgb), .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  logic [CD-1:0] chain [LAT] = '{default: '0};
  always @(posedge clk) begin
    chain[0] <= {x[5:0], y[5:0]};
    for (int i = 1; i < LAT; i++) chain[i] <= chain[i-1];
  end
  assign si_rgb = chain[LAT-1];

  typedef struct {
    logic [CD:0] data;
    int          t;
  } ent_t;

  ent_t q[$];
  int   mx, my, cyc, pops;
  bit   started;
  int   exp_ucnt;
  int   checks, errors;
  logic          s_pix, s_valid;
  logic [10:0]   s_x, s_y;
  logic [CD:0]   s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_valid();
    return (q.size() > 0) && ((cyc - q[0].t) >= LAT + 1);
  endfunction

  // One clock: drive inputs, compare at the falling edge, then advance the model at the rising edge.
  task automatic step(input bit rdy, input bit clr, input bit rst);
    bit   ev, launch;
    ent_t e;
    reset = rst; so_ready = rdy; sync_clr = clr;
    @(negedge clk);
    s_pix = pix_inc; s_valid = so_valid; s_data = so_data; s_x = x; s_y = y;
    if (!rst) begin
      ev = exp_valid();
      check("pix_inc", 32'(pix_inc), 32'(q.size() < DEPTH));
      check("x", 32'(x), mx);
      check("y", 32'(y), my);
      check("so_valid", 32'(so_valid), 32'(ev));
      check("so_data", 32'(so_data), ev ? 32'(q[0].data) : 32'd0);
      check("underrun_cnt", 32'(underrun_cnt), exp_ucnt);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      mx = 0; my = 0; cyc = 0; started = 0; exp_ucnt = 0;
    end else begin
      ev     = exp_valid();
      launch = (q.size() < DEPTH);
`ifdef VSTREAM_UNDERRUN_CNT_EN
      if (started && rdy && !ev && exp_ucnt < 65535) exp_ucnt++;
`endif
      if (ev && rdy) begin
        if (q[0].data[0]) started = 1;
        void'(q.pop_front());
        pops++;
      end
      if (launch) begin
        e.data = {6'(mx), 6'(my), 1'((mx == 0) && (my == 0))};
        e.t    = cyc;
        q.push_back(e);
      end
      if (clr) begin
        mx = 0; my = 0;
      end else if (launch) begin
        if (mx == HMAX - 1) begin
          mx = 0;
          my = (my == VMAX - 1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      cyc++;
    end
    #1;
  endtask

  initial begin
    int drop_cycle;
    int budget;
    checks = 0; errors = 0; pops = 0;
    reset = 1'b1; sync_clr = 1'b0; so_ready = 1'b1;
    step(1, 0, 1);
    step(1, 0, 1);

    // Reset release: first output on cycle LAT+1 carrying pixel (0,0) with frame_start.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      if (i == 0) check("first_launch", {s_pix, s_x, s_y}, {1'b1, 22'd0});
      if (i == 2) check("no_early_valid", 32'(s_valid), 32'd0);
    end
    step(1, 0, 0);
    check("first_valid", 32'(s_valid), 32'd1);
    check("first_data", 32'(s_data), 32'h0001);
    for (int i = 0; i < 2 * HMAX + 20; i++) step(1, 0, 0);

    // Stall from cycle 10 to 30 after a fresh reset.
    step(1, 0, 1);
    drop_cycle = -1;
    for (int c = 0; c < 80; c++) begin
      step(!(c >= 10 && c <= 30), 0, 0);
      if (c >= 10 && drop_cycle < 0 && !s_pix) drop_cycle = c;
    end
    check("stall_drop", 32'(drop_cycle >= 10 && drop_cycle - 10 <= DEPTH), 32'd1);

    // Random back-pressure over two full frames.
    pops = 0;
    budget = 0;
    while (pops < 2 * HMAX * VMAX && budget < 20000) begin
      step(1'($urandom_range(1)), 0, 0);
      budget++;
    end
    check("random_done", 32'(pops >= 2 * HMAX * VMAX), 32'd1);

    // Drain with the sink always ready; any starvation gaps are counted by the model.
    for (int i = 0; i < 40; i++) step(1, 0, 0);

    // sync_clr while launching (100,7).
    step(1, 0, 1);
    budget = 0;
    while (!(mx == 100 && my == 7) && budget < 5000) begin
      step(1, 0, 0);
      budget++;
    end
    check("reach_100_7", {21'(mx), 11'(my)}, {21'd100, 11'd7});
    step(1, 1, 0);
    step(1, 0, 0);
    check("sync_restart", {s_pix, s_x, s_y}, {1'b1, 22'd0});
    for (int i = 0; i < 30; i++) step(1, 0, 0);

    // Reset with the FIFO full, mid-frame.
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    check("reset_valid", 32'(s_valid), 32'd0);
    check("reset_data", 32'(s_data), 32'd0);
    check("reset_xy", {s_x, s_y}, 32'd0);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(3) != 0), 1'($urandom_range(199) == 0), 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
